// File: rtl/adc_rd_ctrl.sv
// adc_rd_ctrl: ADC serial read sequencer; define ADC_AVG_EN to average 4 frames per request
module adc_rd_ctrl #(
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int SETUP_CYC  = 2,
  parameter int CS_GAP     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              miso,
  output logic              cs,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy
);
  localparam int MAX_A = FRAME_BITS > CS_GAP ? FRAME_BITS : CS_GAP;
  localparam int MAX_C = MAX_A > SETUP_CYC ? MAX_A : SETUP_CYC;
  localparam int CW    = $clog2(MAX_C + 1);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Leading frame bits shift out of the top; only bits that can reach dout are held.
  logic [DATA_W-2:0] shift_q;
  logic [DATA_W-1:0] word_d;
  logic              cnt_last, go_d;
  assign word_d   = {shift_q, miso};
  assign cnt_last = cnt_q == CW'((state_q == SETUP ? SETUP_CYC : state_q == SHIFT ? FRAME_BITS : CS_GAP) - 1);
  assign cnt_d    = cnt_last ? '0 : cnt_q + CW'(1);
  assign busy     = state_q != IDLE;
`ifdef ADC_AVG_EN
  logic [DATA_W+1:0] sum_q, sum_d;
  logic [1:0]        frm_q;
  assign sum_d = sum_q + {2'b00, word_d};
  // Frames inside a 4-frame group chain regardless of start/cont.
  assign go_d  = start | cont | (frm_q != 2'd0);
`else
  assign go_d  = start | cont;
`endif
  // Frame sequencer: chip-select, MISO capture and result strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      cs       <= 1'b1;
      dout     <= '0;
      dout_vld <= 1'b0;
`ifdef ADC_AVG_EN
      sum_q    <= '0;
      frm_q    <= 2'd0;
`endif
    end else begin
      dout_vld <= 1'b0;
      case (state_q)
        IDLE: if (go_d) begin
          cs      <= 1'b0;
          cnt_q   <= '0;
          state_q <= SETUP;
        end
        SETUP: begin
          cnt_q <= cnt_d;
          if (cnt_last) state_q <= SHIFT;
        end
        SHIFT: begin
          cnt_q   <= cnt_d;
          shift_q <= word_d[DATA_W-2:0];
          if (cnt_last) begin
            cs      <= 1'b1;
            state_q <= GAP;
`ifdef ADC_AVG_EN
            frm_q   <= frm_q + 2'd1;
            sum_q   <= frm_q == 2'd3 ? '0 : sum_d;
            if (frm_q == 2'd3) begin
              dout     <= sum_d[DATA_W+1:2];
              dout_vld <= 1'b1;
            end
`else
            dout     <= word_d;
            dout_vld <= 1'b1;
`endif
          end
        end
        GAP: begin
          cnt_q <= cnt_d;
          if (cnt_last) begin
            cs      <= !go_d;
            state_q <= go_d ? SETUP : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
